// File: rtl/replay_ctrl.sv
// replay_ctrl: replay buffer sequencer for an 8x16 SRAM with ack/rewind.
// Optional REPLAY_CTRL_STATS_EN enables the saturating replay_cnt counter.
module replay_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          ack,
  input  logic          replay,
  output logic [AW-1:0] sram_w_addr,
  output logic [DW-1:0] sram_din,
  output logic          sram_we,
  output logic [AW-1:0] sram_r_addr,
  output logic          sram_oe,
  input  logic [DW-1:0] sram_dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic [7:0]    replay_cnt
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPT,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [AW:0] wr_ptr, rd_ptr, dl_ptr, ak_ptr;
  logic [AW:0] ak_nx, pending;
  logic        push, ack_ok, deliver;

  assign level    = wr_ptr - ak_ptr;
  assign pending  = wr_ptr - rd_ptr;
  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign in_ready = !full && (state != CAPT);
  assign push     = in_valid && in_ready;

  assign sram_we     = push;
  assign sram_w_addr = wr_ptr[AW-1:0];
  assign sram_din    = push ? in_data : '0;
  assign sram_oe     = (state == CAPT);
  assign sram_r_addr = rd_ptr[AW-1:0];

  assign ack_ok  = ack && (ak_ptr != dl_ptr);
  assign ak_nx   = ack_ok ? ak_ptr + ONE : ak_ptr;
  assign deliver = (state == HOLD) && out_ready && !replay;

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Read FSM next state; replay always returns to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (pending != '0) state_nx = FETCH;
      FETCH: state_nx = CAPT;
      CAPT:  state_nx = HOLD;
      HOLD:  if (out_ready)
               state_nx = (pending != '0) ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
    if (replay) state_nx = IDLE;
  end

  // Pointer updates; ack lands before the replay rewind target is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dl_ptr <= '0;
      ak_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      ak_ptr <= ak_nx;
      if (replay) begin
        rd_ptr <= ak_nx;
        dl_ptr <= ak_nx;
      end else begin
        if (state == FETCH) rd_ptr <= rd_ptr + ONE;
        if (deliver)        dl_ptr <= dl_ptr + ONE;
      end
    end
  end

  // Output register: capture SRAM data in CAPT, drop on delivery or replay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (replay) begin
      out_valid <= 1'b0;
    end else if (state == CAPT) begin
      out_valid <= 1'b1;
      out_data  <= sram_dout;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

`ifdef REPLAY_CTRL_STATS_EN
  logic [7:0] rcnt;

  // Saturating count of cycles with replay asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         rcnt <= '0;
    else if (replay && rcnt != 8'hFF)   rcnt <= rcnt + 8'd1;
  end

  assign replay_cnt = rcnt;
`else
  assign replay_cnt = '0;
`endif

endmodule
